// File: rtl/descrambler_par_if.sv
// Bundle of the frame, data and status signals of descrambler_par.
// The DUT connects via the slave modport; the driving side uses master.
interface descrambler_par_if #(
  parameter int WIDTH    = 1,
  parameter int LFSR_LEN = 7,
  parameter int CNT_W    = 16
);
  logic                enable;
  logic                start;
  logic                mode;
  logic                auto_seed;
  logic [LFSR_LEN-1:0] seed_in;
  logic                in_valid;
  logic [WIDTH-1:0]    in_data;
  logic                in_last;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic                out_last;
  logic [LFSR_LEN-1:0] state_out;
  logic                locked;
  logic [CNT_W-1:0]    frame_bits;
  logic                service_err;

  modport master (
    output enable, start, mode, auto_seed, seed_in, in_valid, in_data, in_last,
    input  out_valid, out_data, out_last, state_out, locked, frame_bits, service_err
  );

  modport slave (
    input  enable, start, mode, auto_seed, seed_in, in_valid, in_data, in_last,
    output out_valid, out_data, out_last, state_out, locked, frame_bits, service_err
  );
endinterface

// File: rtl/descrambler_par.sv
// WIDTH-bit-per-clock 802.11 (x^7+x^4+1) scrambler/descrambler with frame control.
// Optional SERVICE-field check is built only when DESCRAMBLER_SERVICE_CHECK_EN is defined.
module descrambler_par #(
  parameter int WIDTH    = 1,
  parameter int LFSR_LEN = 7,
  parameter int TAP_A    = 7,
  parameter int TAP_B    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  descrambler_par_if.slave    bus
);

  localparam int SC_W = $clog2(LFSR_LEN + 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t              r_fsm;
  logic [LFSR_LEN-1:0] r_lfsr;
  logic [SC_W-1:0]     r_syncCnt;
  logic [CNT_W-1:0]    r_frameBits;
  logic                r_outValid;
  logic [WIDTH-1:0]    r_outData;
  logic                r_outLast;
  logic                r_locked;

  logic                w_accept;
  state_t              w_fsm;
  logic [LFSR_LEN-1:0] w_lfsr;
  logic [SC_W-1:0]     w_cnt;
  logic [CNT_W-1:0]    w_base;
  logic [CNT_W-1:0]    w_bits;
  logic [CNT_W:0]      w_sum;
  logic [WIDTH-1:0]    w_out;
  logic                w_fb;

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
  localparam int SERVICE_BITS = 16;
  logic r_chkFrame;
  logic r_serviceErr;
  logic w_chk;
  logic w_err;
`endif

  assign w_accept = bus.enable & bus.in_valid & ((r_fsm != IDLE) | bus.start);

  // Apply any start first, then walk the beat bit by bit so a beat may straddle SYNC->RUN.
  always_comb begin
    w_fsm  = r_fsm;
    w_lfsr = r_lfsr;
    w_cnt  = r_syncCnt;
    w_base = r_frameBits;
    w_out  = '0;
    w_fb   = 1'b0;
    w_sum  = '0;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
    w_chk  = bus.start ? (~bus.mode & bus.auto_seed) : r_chkFrame;
    w_err  = bus.start ? 1'b0 : r_serviceErr;
`endif
    if (bus.start) begin
      w_cnt  = '0;
      w_base = '0;
      if (!bus.mode && bus.auto_seed) begin
        w_fsm  = SYNC;
        w_lfsr = '0;
      end else begin
        w_fsm  = RUN;
        w_lfsr = bus.seed_in;
      end
    end
    w_bits = w_base;
    if (w_accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_fsm == SYNC) begin
          w_lfsr = {w_lfsr[LFSR_LEN-2:0], bus.in_data[i]};
          w_cnt  = w_cnt + SC_W'(1);
          if (w_cnt == SC_W'(LFSR_LEN)) w_fsm = RUN;
        end else begin
          w_fb     = w_lfsr[TAP_A-1] ^ w_lfsr[TAP_B-1];
          w_out[i] = bus.in_data[i] ^ w_fb;
          w_lfsr   = {w_lfsr[LFSR_LEN-2:0], w_fb};
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
          if (w_chk && w_out[i] && (int'(w_base) + i >= LFSR_LEN) &&
              (int'(w_base) + i < SERVICE_BITS))
            w_err = 1'b1;
`endif
        end
      end
      if (bus.in_last) w_fsm = IDLE;
      w_sum  = {1'b0, w_base} + (CNT_W+1)'(WIDTH);
      w_bits = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fsm       <= IDLE;
      r_lfsr      <= '0;
      r_syncCnt   <= '0;
      r_frameBits <= '0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outLast   <= 1'b0;
      r_locked    <= 1'b0;
    end else if (bus.enable) begin
      r_fsm       <= w_fsm;
      r_lfsr      <= w_lfsr;
      r_syncCnt   <= w_cnt;
      r_frameBits <= w_bits;
      r_outValid  <= w_accept;
      r_outData   <= w_accept ? w_out : '0;
      r_outLast   <= w_accept & bus.in_last;
      r_locked    <= (w_fsm == RUN);
    end
  end

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
  // Sticky until the next start; only auto-seed descramble frames are checked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chkFrame   <= 1'b0;
      r_serviceErr <= 1'b0;
    end else if (bus.enable) begin
      r_chkFrame   <= w_chk;
      r_serviceErr <= w_err;
    end
  end

  assign bus.service_err = r_serviceErr;
`else
  assign bus.service_err = 1'b0;
`endif

  assign bus.out_valid  = r_outValid;
  assign bus.out_data   = r_outData;
  assign bus.out_last   = r_outLast;
  assign bus.state_out  = r_lfsr;
  assign bus.locked     = r_locked;
  assign bus.frame_bits = r_frameBits;

endmodule

// File: tb/tb_descrambler_par.sv
// Directed bench for descrambler_par: a WIDTH=1 instance and a WIDTH=4 instance (CNT_W=5 to reach saturation).
// Expected sequences are hand-derived from the x^7+x^4+1 recurrence.
module tb_descrambler_par;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [0:15] expSeq;
  logic [31:0] origBits;
  logic [31:0] scrBits;
  logic [3:0]  beats [4];

  descrambler_par_if #(.WIDTH(1), .LFSR_LEN(7), .CNT_W(16)) b1 ();
  descrambler_par_if #(.WIDTH(4), .LFSR_LEN(7), .CNT_W(5))  b4 ();

  descrambler_par #(.WIDTH(1), .LFSR_LEN(7), .TAP_A(7), .TAP_B(4), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .bus(b1)
  );

  descrambler_par #(.WIDTH(4), .LFSR_LEN(7), .TAP_A(7), .TAP_B(4), .CNT_W(5)) dut4 (
    .clock(clock), .reset(reset), .bus(b4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one DUT for a single cycle (the other idles), then step to just after the edge.
  task automatic applyStimulus(input int which, input logic st, input logic md, input logic au,
                               input logic [6:0] sd, input logic vl, input logic [3:0] dt,
                               input logic ls, input logic en);
    b1.enable = 1'b1; b1.start = 1'b0; b1.in_valid = 1'b0; b1.in_last = 1'b0;
    b4.enable = 1'b1; b4.start = 1'b0; b4.in_valid = 1'b0; b4.in_last = 1'b0;
    if (which == 1) begin
      b1.enable = en; b1.start = st; b1.mode = md; b1.auto_seed = au; b1.seed_in = sd;
      b1.in_valid = vl; b1.in_data = dt[0]; b1.in_last = ls;
    end else begin
      b4.enable = en; b4.start = st; b4.mode = md; b4.auto_seed = au; b4.seed_in = sd;
      b4.in_valid = vl; b4.in_data = dt; b4.in_last = ls;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expSeq = 16'b0000111011110010;
    beats[0] = 4'h0; beats[1] = 4'h7; beats[2] = 4'hF; beats[3] = 4'h4;
    reset = 1'b0;
    b1.enable = 1'b1; b1.start = 1'b0; b1.mode = 1'b0; b1.auto_seed = 1'b0; b1.seed_in = '0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0;
    b4.enable = 1'b1; b4.start = 1'b0; b4.mode = 1'b0; b4.auto_seed = 1'b0; b4.seed_in = '0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0;
    #12;
    checkOutput("rst_valid", b1.out_valid, 0);
    checkOutput("rst_state", b1.state_out, 0);
    checkOutput("rst_locked", b1.locked, 0);
    checkOutput("rst_bits", b1.frame_bits, 0);
    checkOutput("rst_serr", b4.service_err, 0);
    reset = 1'b1;

    $display("[TB] scramble 16 zeros, seed 7F");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, k == 0, 1'b1, 1'b0, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1);
      checkOutput("t1_valid", b1.out_valid, 1);
      checkOutput("t1_data", b1.out_data, expSeq[k]);
      checkOutput("t1_locked", b1.locked, 1);
    end
    checkOutput("t1_bits", b1.frame_bits, 16);
    checkOutput("t1_state", b1.state_out, 7'h72);

    $display("[TB] round trip 32 random bits, seed 5D");
    origBits = $urandom;
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1, k == 0, 1'b1, 1'b0, 7'h5D, 1'b1, {3'b000, origBits[k]}, 1'b0, 1'b1);
      checkOutput("t2_scr_valid", b1.out_valid, 1);
      scrBits[k] = b1.out_data[0];
    end
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1, k == 0, 1'b0, 1'b0, 7'h5D, 1'b1, {3'b000, scrBits[k]}, k == 31, 1'b1);
      checkOutput("t2_valid", b1.out_valid, 1);
      checkOutput("t2_data", b1.out_data, origBits[k]);
    end
    checkOutput("t2_last", b1.out_last, 1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 7'h5D, 1'b1, 4'h1, 1'b0, 1'b1);
    checkOutput("t2_idle_valid", b1.out_valid, 0);
    checkOutput("t2_idle_locked", b1.locked, 0);
    checkOutput("t2_idle_bits", b1.frame_bits, 32);

    $display("[TB] zero seed passes data through");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 4'h1, 1'b0, 1'b1);
    checkOutput("t0_d0", b1.out_data, 1);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 4'h0, 1'b0, 1'b1);
    checkOutput("t0_d1", b1.out_data, 0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 4'h1, 1'b0, 1'b1);
    checkOutput("t0_d2", b1.out_data, 1);
    checkOutput("t0_state", b1.state_out, 0);

    $display("[TB] WIDTH=4 auto-seed sync on scrambled stream");
    applyStimulus(4, 1'b1, 1'b0, 1'b1, 7'h55, 1'b1, beats[0], 1'b0, 1'b1);
    checkOutput("t3_b0_data", b4.out_data, 0);
    checkOutput("t3_b0_locked", b4.locked, 0);
    checkOutput("t3_b0_bits", b4.frame_bits, 4);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[1], 1'b0, 1'b1);
    checkOutput("t3_b1_data", b4.out_data, 0);
    checkOutput("t3_b1_locked", b4.locked, 1);
    checkOutput("t3_b1_state", b4.state_out, 7'h0E);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[2], 1'b0, 1'b1);
    checkOutput("t3_b2_data", b4.out_data, 0);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[3], 1'b1, 1'b1);
    checkOutput("t3_b3_data", b4.out_data, 0);
    checkOutput("t3_b3_last", b4.out_last, 1);
    checkOutput("t3_b3_state", b4.state_out, 7'h72);
    checkOutput("t3_b3_bits", b4.frame_bits, 16);
    checkOutput("t3_serr", b4.service_err, 0);

    $display("[TB] WIDTH=4 auto-seed with bit 9 flipped");
    applyStimulus(4, 1'b1, 1'b0, 1'b1, 7'h55, 1'b1, beats[0], 1'b0, 1'b1);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[1], 1'b0, 1'b1);
    checkOutput("t4_b1_serr", b4.service_err, 0);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[2] ^ 4'h2, 1'b0, 1'b1);
    checkOutput("t4_b2_data", b4.out_data, 4'h2);
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
    checkOutput("t4_b2_serr", b4.service_err, 1);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[3], 1'b1, 1'b1);
    checkOutput("t4_b3_serr", b4.service_err, 1);
`else
    checkOutput("t4_b2_serr", b4.service_err, 0);
    applyStimulus(4, 1'b0, 1'b0, 1'b1, 7'h55, 1'b1, beats[3], 1'b1, 1'b1);
    checkOutput("t4_b3_serr", b4.service_err, 0);
`endif
    applyStimulus(4, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("t4_clr_serr", b4.service_err, 0);
    checkOutput("t4_clr_bits", b4.frame_bits, 0);

    $display("[TB] WIDTH=4 frame_bits saturation at 31");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4, k == 0, 1'b1, 1'b0, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1);
      if (k == 6) checkOutput("sat_28", b4.frame_bits, 28);
      if (k == 7) checkOutput("sat_32", b4.frame_bits, 31);
    end
    checkOutput("sat_36", b4.frame_bits, 31);

    $display("[TB] enable stall mid-frame");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, k == 0, 1'b1, 1'b0, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1);
      checkOutput("t5_pre_data", b1.out_data, expSeq[k]);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1'b1, 1'b0, 1'b1, 7'h11, 1'b1, 4'h1, 1'b0, 1'b0);
      checkOutput("t5_hold_valid", b1.out_valid, 1);
      checkOutput("t5_hold_data", b1.out_data, expSeq[7]);
      checkOutput("t5_hold_state", b1.state_out, 7'h0E);
      checkOutput("t5_hold_bits", b1.frame_bits, 8);
    end
    for (int k = 8; k < 16; k++) begin
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1);
      checkOutput("t5_post_data", b1.out_data, expSeq[k]);
    end
    checkOutput("t5_state", b1.state_out, 7'h72);
    checkOutput("t5_bits", b1.frame_bits, 16);

    $display("[TB] asynchronous reset mid-RUN");
    b1.in_valid = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t6_valid", b1.out_valid, 0);
    checkOutput("t6_state", b1.state_out, 0);
    checkOutput("t6_bits", b1.frame_bits, 0);
    checkOutput("t6_locked", b1.locked, 0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1);
      checkOutput("t6_idle_valid", b1.out_valid, 0);
      checkOutput("t6_idle_bits", b1.frame_bits, 0);
    end
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1);
    checkOutput("t6_restart_valid", b1.out_valid, 1);
    checkOutput("t6_restart_data", b1.out_data, expSeq[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/descrambler_par.md
Name: descrambler_par

Overview:
- Parametrised next-generation 802.11 (x^7+x^4+1) scrambler/descrambler, WIDTH bits per clock.
- Adds frame control (start/last), a runtime scramble/descramble mode, seed load or auto-seed recovery from the SERVICE field, and a per-frame bit counter.
- Sits between the PHY bit deinterleaver/decoder and the MAC bit sink. The same block also serves the TX scrambling path.

Parameters:
- WIDTH, 1, bits processed per accepted beat (1..8); in_data[0] is the earliest bit in time.
- LFSR_LEN, 7, scrambler register length.
- TAP_A, 7, first feedback tap (1-based).
- TAP_B, 4, second feedback tap (1-based).
- CNT_W, 16, width of the frame_bits counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global stall; no beat is accepted and no state changes while low.
- start  in  1  single-cycle pulse that begins a frame.
- mode  in  1  0 = descramble, 1 = scramble; sampled on start.
- auto_seed  in  1  1 = recover the seed from the first 7 bits; sampled on start; ignored when mode=1.
- seed_in  in  LFSR_LEN  initial state used on start when not auto-seeding.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  input bits.
- in_last  in  1  the current beat ends the frame.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  output bits, same ordering as in_data.
- out_last  out  1  registered copy of in_last for the accepted beat.
- state_out  out  LFSR_LEN  current LFSR state.
- locked  out  1  LFSR state is valid (seeded or sync complete).
- frame_bits  out  CNT_W  bits processed in the current frame, saturating.
- service_err  out  1  SERVICE check failure (see Optional Feature).

Behaviour:
- Reset values (reset low, asynchronous): all outputs 0, state_out 0, FSM IDLE.
- Per-bit LFSR rule, state s[LFSR_LEN-1:0]:
  - fb = s[TAP_A-1] ^ s[TAP_B-1].
  - RUN: out = in ^ fb, s <= {s[LFSR_LEN-2:0], fb}.
  - SYNC: out = 0, s <= {s[LFSR_LEN-2:0], in}. The recovered state is therefore the last 7 received bits.
  - Bits within one beat are unrolled in order 0..WIDTH-1. A beat may straddle SYNC→RUN; per-bit selection uses sync_cnt.
- Accept condition: accepted = enable & in_valid & (fsm != IDLE, or start this cycle).
- Latency: 1 cycle. Registered out_valid/out_data/out_last are updated every enabled cycle; out_valid=0 when no beat is accepted. With enable low, outputs are held.
- FSM:
  - IDLE: on start → SYNC if (mode=0 & auto_seed), else RUN with s <= seed_in.
  - SYNC: sync_cnt counts 0..LFSR_LEN. When LFSR_LEN bits have been consumed → RUN.
  - RUN: remains in RUN until an accepted beat carries in_last → IDLE.
- start in any state restarts the frame: sync_cnt, frame_bits and service_err are cleared. An in_valid beat in the same cycle is processed as the first beat of the new frame, using the new seed or sync rule.
- in_last during SYNC: frame ends, back to IDLE, locked stays 0.
- locked: 1 in RUN; 0 in IDLE/SYNC. Cleared on start only if auto-seeding.
- frame_bits: += WIDTH per accepted beat, saturating at all-ones; held after in_last until the next start.
- Seed all zeros: the LFSR locks at 0 and the block passes data through unchanged. This is required behaviour with no error flag.

Optional Feature:
- Macro: DESCRAMBLER_SERVICE_CHECK_EN.
- Defined: in auto-seed descramble frames, descrambled bits 7..15 (the SERVICE remainder) must be 0.
  - Any 1 among them sets service_err one cycle after the offending beat.
  - service_err is sticky until the next start or reset.
- Not defined: service_err is tied to 0 and no check logic is built.

Test Plan:
1. WIDTH=1, mode=1, seed_in=7'h7F, 16 zero bits → out_data sequence 0000111011110010, locked=1 throughout, frame_bits=16.
2. Scramble 32 random bits with seed 7'h5D (WIDTH=1), then feed the result back with mode=0, auto_seed=0, seed 7'h5D → original bits recovered, 1-cycle latency each beat.
3. WIDTH=4, auto_seed=1, feed the scrambled output of test 1 (seed 7'h7F) → first 7 output bits 0, locked rises after beat 2, state_out=7'h7F-derived value, remaining bits 0; service_err=0 with macro defined.
4. Same as 3 but flip in_data bit 9 → service_err=1 from the cycle after beat 3; a start pulse clears it to 0.
5. Toggle enable low for 3 cycles mid-frame → state_out, frame_bits and outputs frozen; resuming yields an identical sequence to the uninterrupted run.
6. Assert reset low mid-RUN with in_valid high → all outputs 0 immediately (asynchronous). After release, the FSM is in IDLE and beats are ignored until start.
